t2c_maze_env: RTL and testbench

- Maze-side responder for the MazeSolver bot. It holds a 9x9 wall map, consumes the bot's 3-bit move command every clock and tracks bot position and heading.
- It drives the left/mid/right wall sensors back to the bot.
- It flags exit, crash and illegal-command events, and counts steps and dead-ends.
- Used as the closed-loop environment around the explorer in simulation and on-board self-test.

---
 rtl/t2c_maze_env.sv | 221 ++++++++++++++++++++++
 tb/tb_t2c_maze_env.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/t2c_maze_env.sv
// Maze-side responder for the MazeSolver bot: wall map, bot pose tracking,
// wall sensors and run status/event counters.
module t2c_maze_env #(
    parameter int ROWS    = 9,
    parameter int COLS    = 9,
    parameter int START_X = 4,
    parameter int START_Y = 8,
    parameter int EXIT_X  = 4,
    parameter int EXIT_Y  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [6:0]  cfg_addr,
    input  logic [3:0]  cfg_walls,
    input  logic        cfg_start,
    input  logic [2:0]  move,
    output logic        left,
    output logic        mid,
    output logic        right,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  heading,
    output logic        running,
    output logic        exit_reached,
    output logic        crash,
    output logic        bad_cmd,
    output logic [15:0] step_count,
    output logic [3:0]  deadend_count
);

    localparam int CELLS = ROWS * COLS;

    localparam logic [2:0] MV_STOP = 3'd0;
    localparam logic [2:0] MV_FWD  = 3'd1;
    localparam logic [2:0] MV_LEFT = 3'd2;
    localparam logic [2:0] MV_RGT  = 3'd3;
    localparam logic [2:0] MV_UTRN = 3'd4;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    function automatic logic [6:0] cell_idx(logic [3:0] x, logic [3:0] y);
        return 7'(y) * 7'(COLS) + 7'(x);
    endfunction

    // Walls are packed {N,E,S,W}, so direction d lives at bit 3-d.
    function automatic logic wall_at(logic [3:0] w, logic [1:0] d);
        return w[2'd3 - d];
    endfunction

    logic [3:0] wall_mem [CELLS];

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [1:0]  hd_q, hd_d;
    logic        exit_q, exit_d;
    logic        crash_q, crash_d;
    logic        bad_q, bad_d;
    logic [15:0] steps_q, steps_d;
    logic [3:0]  dead_q, dead_d;

    logic [3:0]  cur_walls;
    logic [3:0]  tgt_walls;
    logic [6:0]  cur_idx;
    logic [6:0]  tgt_idx;
    logic [1:0]  tgt_dir;
    logic [3:0]  nx;
    logic [3:0]  ny;
    logic        off_grid;
    logic        blocked;
    logic        we_ok;

    assign we_ok = cfg_we && (state_q == S_LOAD) && (32'(cfg_addr) < CELLS);

    always_ff @(posedge clk) begin
        if (we_ok) begin
            wall_mem[cfg_addr] <= cfg_walls;
        end
    end

    always_comb begin
        tgt_dir = hd_q;
        unique case (move)
            MV_LEFT: tgt_dir = hd_q - 2'd1;
            MV_RGT:  tgt_dir = hd_q + 2'd1;
            MV_UTRN: tgt_dir = hd_q + 2'd2;
            default: tgt_dir = hd_q;
        endcase
    end

    always_comb begin
        nx       = x_q;
        ny       = y_q;
        off_grid = 1'b0;
        unique case (tgt_dir)
            DIR_N: begin
                ny       = y_q - 4'd1;
                off_grid = (y_q == 4'd0);
            end
            DIR_E: begin
                nx       = x_q + 4'd1;
                off_grid = (32'(x_q) == COLS - 1);
            end
            DIR_S: begin
                ny       = y_q + 4'd1;
                off_grid = (32'(y_q) == ROWS - 1);
            end
            DIR_W: begin
                nx       = x_q - 4'd1;
                off_grid = (x_q == 4'd0);
            end
            default: ;
        endcase
    end

    // Off-grid targets fall back to the current cell to keep the read in range.
    assign cur_idx   = cell_idx(x_q, y_q);
    assign tgt_idx   = off_grid ? cur_idx : cell_idx(nx, ny);
    assign cur_walls = wall_mem[cur_idx];
    assign tgt_walls = wall_mem[tgt_idx];
    assign blocked   = off_grid || wall_at(cur_walls, tgt_dir);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hd_d    = hd_q;
        exit_d  = exit_q;
        crash_d = crash_q;
        bad_d   = bad_q;
        steps_d = steps_q;
        dead_d  = dead_q;
        unique case (state_q)
            S_LOAD: begin
                if (cfg_start) begin
                    state_d = S_RUN;
                    x_d     = 4'(START_X);
                    y_d     = 4'(START_Y);
                    hd_d    = DIR_N;
                    steps_d = 16'd0;
                    dead_d  = 4'd0;
                end
            end
            S_RUN: begin
                if (move > MV_UTRN) begin
                    bad_d   = 1'b1;
                    state_d = S_FAULT;
                end else if (move != MV_STOP) begin
                    if (blocked) begin
                        crash_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        x_d  = nx;
                        y_d  = ny;
                        hd_d = tgt_dir;
                        if (steps_q != 16'hFFFF) begin
                            steps_d = steps_q + 16'd1;
                        end
                        if (($countones(tgt_walls) == 3) && (dead_q != 4'hF)) begin
                            dead_d = dead_q + 4'd1;
                        end
                        if ((32'(nx) == EXIT_X) && (32'(ny) == EXIT_Y)) begin
                            exit_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            x_q     <= 4'(START_X);
            y_q     <= 4'(START_Y);
            hd_q    <= DIR_N;
            exit_q  <= 1'b0;
            crash_q <= 1'b0;
            bad_q   <= 1'b0;
            steps_q <= 16'd0;
            dead_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hd_q    <= hd_d;
            exit_q  <= exit_d;
            crash_q <= crash_d;
            bad_q   <= bad_d;
            steps_q <= steps_d;
            dead_q  <= dead_d;
        end
    end

    assign mid           = wall_at(cur_walls, hd_q);
    assign right         = wall_at(cur_walls, hd_q + 2'd1);
    assign left          = wall_at(cur_walls, hd_q + 2'd3);
    assign pos_x         = x_q;
    assign pos_y         = y_q;
    assign heading       = hd_q;
    assign running       = (state_q == S_RUN);
    assign exit_reached  = exit_q;
    assign crash         = crash_q;
    assign bad_cmd       = bad_q;
    assign step_count    = steps_q;
    assign deadend_count = dead_q;

endmodule

// File: tb/tb_t2c_maze_env.sv
// Directed self-checking bench for t2c_maze_env.
// Map loads, exit run, crash, dead-end, bad command and mid-run reset.
module tb_t2c_maze_env;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [6:0]  cfg_addr;
    logic [3:0]  cfg_walls;
    logic        cfg_start;
    logic [2:0]  move;
    logic        left, mid, right;
    logic [3:0]  pos_x, pos_y;
    logic [1:0]  heading;
    logic        running, exit_reached, crash, bad_cmd;
    logic [15:0] step_count;
    logic [3:0]  deadend_count;

    int checks   = 0;
    int failures = 0;

    t2c_maze_env dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_walls(cfg_walls), .cfg_start(cfg_start), .move(move),
        .left(left), .mid(mid), .right(right),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .running(running), .exit_reached(exit_reached), .crash(crash),
        .bad_cmd(bad_cmd), .step_count(step_count),
        .deadend_count(deadend_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [3:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = 7'(y * 9 + x);
        cfg_walls = w;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        move = 3'd0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic mv(input logic [2:0] m);
        move = m;
        tick();
        move = 3'd0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_walls = '0;
        cfg_start = 1'b0; move = 3'd0;
        tick();
        tick();
        chk("rst_x", 32'(pos_x), 32'd4);
        chk("rst_y", 32'(pos_y), 32'd8);
        chk("rst_hd", 32'(heading), 32'd0);
        chk("rst_flags", {28'd0, running, exit_reached, crash, bad_cmd}, 32'd0);
        chk("rst_cnt", {12'd0, step_count, deadend_count}, 32'd0);
        rst = 1'b0;

        for (int y = 0; y < 9; y++) begin
            for (int x = 0; x < 9; x++) begin
                wr(x, y, {y == 0, x == 8, y == 8, x == 0});
            end
        end
        start();
        chk("run1_running", 32'(running), 32'd1);
        for (int i = 0; i < 7; i++) mv(3'd1);
        chk("run1_y7", 32'(pos_y), 32'd1);
        chk("run1_exit_early", 32'(exit_reached), 32'd0);
        mv(3'd1);
        chk("run1_pos", {24'd0, pos_x, pos_y}, 32'h40);
        chk("run1_exit", 32'(exit_reached), 32'd1);
        chk("run1_steps", 32'(step_count), 32'd8);
        chk("run1_running_off", 32'(running), 32'd0);
        mv(3'd1);
        mv(3'd3);
        chk("run1_frozen_pos", {24'd0, pos_x, pos_y}, 32'h40);
        chk("run1_frozen_hd", 32'(heading), 32'd0);
        chk("run1_no_crash", 32'(crash), 32'd0);
        chk("run1_frozen_steps", 32'(step_count), 32'd8);

        do_reset();
        wr(4, 8, 4'b1010);
        start();
        chk("s2_mid", 32'(mid), 32'd1);
        chk("s2_lr", {30'd0, left, right}, 32'd0);
        mv(3'd3);
        chk("s2_hd", 32'(heading), 32'd1);
        chk("s2_pos", {24'd0, pos_x, pos_y}, 32'h58);
        chk("s2_steps", 32'(step_count), 32'd1);

        do_reset();
        wr(4, 8, 4'b1101);
        start();
        mv(3'd1);
        chk("s3_crash", 32'(crash), 32'd1);
        chk("s3_pos", {24'd0, pos_x, pos_y}, 32'h48);
        chk("s3_steps", 32'(step_count), 32'd0);
        chk("s3_running", 32'(running), 32'd0);
        mv(3'd3);
        chk("s3_frozen", {22'd0, pos_x, pos_y, heading}, {22'd0, 4'd4, 4'd8, 2'd0});

        do_reset();
        wr(4, 8, 4'b0010);
        wr(4, 7, 4'b0100);
        wr(4, 6, 4'b1101);
        start();
        mv(3'd1);
        chk("s4_sens_47", {29'd0, left, mid, right}, 32'b001);
        chk("s4_dead0", 32'(deadend_count), 32'd0);
        mv(3'd1);
        chk("s4_pos_46", {24'd0, pos_x, pos_y}, 32'h46);
        chk("s4_dead1", 32'(deadend_count), 32'd1);
        chk("s4_sens_46", {29'd0, left, mid, right}, 32'b111);
        mv(3'd4);
        chk("s4_ut_pos", {24'd0, pos_x, pos_y}, 32'h47);
        chk("s4_ut_hd", 32'(heading), 32'd2);
        chk("s4_ut_sens", {29'd0, left, mid, right}, 32'b100);
        chk("s4_ut_cnt", {12'd0, step_count, deadend_count}, {12'd0, 16'd3, 4'd1});

        do_reset();
        start();
        wr(4, 7, 4'b1111);
        mv(3'd6);
        chk("s5_bad", 32'(bad_cmd), 32'd1);
        chk("s5_pos", {22'd0, pos_x, pos_y, heading}, {22'd0, 4'd4, 4'd8, 2'd0});
        chk("s5_running", 32'(running), 32'd0);
        chk("s5_crash", 32'(crash), 32'd0);

        do_reset();
        wr(4, 6, 4'b0000);
        start();
        for (int i = 0; i < 5; i++) mv(3'd1);
        chk("s6_pos", {24'd0, pos_x, pos_y}, 32'h43);
        chk("s6_steps", 32'(step_count), 32'd5);
        do_reset();
        chk("s6_rst_pos", {22'd0, pos_x, pos_y, heading}, {22'd0, 4'd4, 4'd8, 2'd0});
        chk("s6_rst_cnt", {12'd0, step_count, deadend_count}, 32'd0);
        chk("s6_rst_running", 32'(running), 32'd0);
        start();
        mv(3'd1);
        chk("s6_restart_pos", {24'd0, pos_x, pos_y}, 32'h47);
        chk("s6_ram_kept", {29'd0, left, mid, right}, 32'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
